// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon pattern store: colour and state
// encodings, default geometry and the colour-to-one-hot decode.
package simon_pkg;

  typedef enum logic [1:0] {
    YELLOW = 2'd0,
    RED    = 2'd1,
    BLUE   = 2'd2,
    GREEN  = 2'd3
  } colour_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int          DEPTH_DEF = 16;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;

  // Bit order of the result is {Green, Blue, Red, Yellow}.
  function automatic logic [3:0] colour_onehot(colour_e c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_sequence_if.sv
// Control strobes from the game FSM and status/colour lines back to it.
interface simon_sequence_if;
  logic START;
  logic I_en;
  logic I_cl;
  logic J_en;
  logic J_cl;
  logic Yellow;
  logic Red;
  logic Blue;
  logic Green;
  logic I_eq_J;
  logic J_max;
  logic rand_done;

  modport master (
    output START, I_en, I_cl, J_en, J_cl,
    input  Yellow, Red, Blue, Green, I_eq_J, J_max, rand_done
  );

  modport slave (
    input  START, I_en, I_cl, J_en, J_cl,
    output Yellow, Red, Blue, Green, I_eq_J, J_max, rand_done
  );
endinterface

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/simon_sequence.sv
// Simon pattern RAM, fill FSM and I/J index counters.
// Build option NO_REPEAT_EN: bump a fill colour that would equal its predecessor.
module simon_sequence
  import simon_pkg::*;
#(
  parameter int          DEPTH = DEPTH_DEF,
  parameter logic [15:0] SEED  = SEED_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  simon_sequence_if.slave  bus
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] MAX_IDX = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic          start_q, start_prev_q;
  logic [AW-1:0] a_q, a_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;
  logic          rand_done_q, rand_done_d;
  logic [3:0]    colour_q, colour_d;
  logic          wr_en;
  logic [1:0]    wr_data;
  logic          start_rise;
  logic [15:0]   lfsr_state;
  logic [13:0]   unused_lfsr;
  logic [1:0]    mem [DEPTH];

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (CLK),
    .rst_n (RESET_N),
    .state (lfsr_state)
  );

  assign unused_lfsr = lfsr_state[15:2];
  // Edge detect on the registered copy so START is seen one stage late.
  assign start_rise  = start_q & ~start_prev_q;

`ifdef NO_REPEAT_EN
  logic [1:0] last_q, last_d;

  always_comb begin
    wr_data = lfsr_state[1:0];
    if ((a_q != '0) && (lfsr_state[1:0] == last_q)) begin
      wr_data = lfsr_state[1:0] + 2'd1;
    end
    last_d = wr_en ? wr_data : last_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign wr_data = lfsr_state[1:0];
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    i_d         = i_q;
    j_d         = j_q;
    rand_done_d = rand_done_q;
    colour_d    = '0;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        a_d = '0;
        if (start_rise) begin
          state_d = FILL;
        end
      end
      FILL: begin
        wr_en = 1'b1;
        a_d   = a_q + AW'(1);
        if (a_q == MAX_IDX) begin
          state_d     = READY;
          rand_done_d = 1'b1;
        end
      end
      READY: begin
        if (start_rise) begin
          state_d     = FILL;
          rand_done_d = 1'b0;
          a_d         = '0;
          i_d         = '0;
          j_d         = '0;
        end else begin
          colour_d = colour_onehot(colour_e'(mem[i_q]));
          if (bus.I_cl) begin
            i_d = '0;
          end else if (bus.I_en) begin
            i_d = i_q + AW'(1);
          end
          if (bus.J_cl) begin
            j_d = '0;
          end else if (bus.J_en && (j_q != MAX_IDX)) begin
            j_d = j_q + AW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      a_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      rand_done_q  <= 1'b0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= bus.START;
      start_prev_q <= start_q;
      a_q          <= a_d;
      i_q          <= i_d;
      j_q          <= j_d;
      rand_done_q  <= rand_done_d;
      colour_q     <= colour_d;
    end
  end

  // Pattern RAM carries no reset; its contents only matter once READY.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[a_q] <= wr_data;
    end
  end

  assign bus.Yellow    = colour_q[0];
  assign bus.Red       = colour_q[1];
  assign bus.Blue      = colour_q[2];
  assign bus.Green     = colour_q[3];
  assign bus.rand_done = rand_done_q;
  assign bus.I_eq_J    = (i_q == j_q);
  assign bus.J_max     = (j_q == MAX_IDX);

endmodule

// File: tb/tb_simon_sequence.sv
// Directed bench for simon_sequence: vector table plus fill/reset/wrap sequences.
// Honours NO_REPEAT_EN the same way the design does.
module tb_simon_sequence;

  logic clk;
  logic rst_n;
  simon_sequence_if bus();

  simon_sequence #(.DEPTH(16), .SEED(16'hACE1)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR, reset together with the DUT and stepped on every edge.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    logic       ien, icl, jen, jcl;
    logic [3:0] ei;
    logic       eeq, emax;
  } vec_t;

  int         vectors = 0;
  int         errors  = 0;
  int         repeats = 0;
  logic [1:0] expm [16];
  vec_t       tbl [10];

  function automatic logic [3:0] col();
    return {bus.Green, bus.Blue, bus.Red, bus.Yellow};
  endfunction

  function automatic logic [3:0] oh(logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input logic ien, input logic icl, input logic jen, input logic jcl);
    bus.I_en = ien; bus.I_cl = icl; bus.J_en = jen; bus.J_cl = jcl;
    @(posedge clk); #1;
    bus.I_en = 1'b0; bus.I_cl = 1'b0; bus.J_en = 1'b0; bus.J_cl = 1'b0;
  endtask

  // Pulse START, build expected RAM image, check fill latency, then read all 16 entries.
  task automatic game(input int id);
    logic [1:0] raw;
    int         lat;
    lat = -1;
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (n <= 16) begin
        raw = m_lfsr[1:0];
`ifdef NO_REPEAT_EN
        if (n > 1 && raw == expm[n-2]) raw = raw + 2'd1;
`endif
        expm[n-1] = raw;
      end
      if (bus.rand_done) lat = n;
    end
    check("fill_latency", lat, 17);
    bus.I_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      check("readback_colour", col(), oh(expm[k-1]));
      if (k > 1 && expm[k-1] == expm[k-2]) repeats++;
    end
    bus.I_en = 1'b0;
    $display("game %0d: latency %0d, pattern %0h%0h%0h%0h%0h%0h%0h%0h%0h%0h%0h%0h%0h%0h%0h%0h",
             id, lat, expm[0], expm[1], expm[2], expm[3], expm[4], expm[5], expm[6], expm[7],
             expm[8], expm[9], expm[10], expm[11], expm[12], expm[13], expm[14], expm[15]);
  endtask

  initial begin
    logic [3:0] prev_i;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0};

    bus.START = 1'b0; bus.I_en = 1'b0; bus.I_cl = 1'b0; bus.J_en = 1'b0; bus.J_cl = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_colour_in", col(), 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_colour", col(), 4'h0);
    check("reset_rand_done", bus.rand_done, 1'b0);
    check("reset_i_eq_j", bus.I_eq_J, 1'b1);
    check("reset_j_max", bus.J_max, 1'b0);

    game(0);

    prev_i = 4'd0;
    for (int v = 0; v < 10; v++) begin
      tick(tbl[v].ien, tbl[v].icl, tbl[v].jen, tbl[v].jcl);
      check("vec_i_eq_j", bus.I_eq_J, tbl[v].eeq);
      check("vec_j_max", bus.J_max, tbl[v].emax);
      check("vec_colour", col(), oh(expm[prev_i]));
      $display("vec %0d: I_eq_J=%0b J_max=%0b colour=%0h", v, bus.I_eq_J, bus.J_max, col());
      prev_i = tbl[v].ei;
    end

    tick(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("jsat_j_max", bus.J_max, (k >= 15));
      check("jsat_i_eq_j", bus.I_eq_J, 1'b0);
    end
    $display("J saturation: J_max=%0b after 20 increments", bus.J_max);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("jcl_j_max", bus.J_max, 1'b0);
    check("jcl_i_eq_j", bus.I_eq_J, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("iwrap_i_eq_j", bus.I_eq_J, (k == 16));
      check("iwrap_colour", col(), oh(expm[k-1]));
    end
    $display("I wrap: I_eq_J=%0b after 16 increments", bus.I_eq_J);

    // Async reset from READY while a colour is lit: must drop between edges.
    @(posedge clk); #2;
    check("pre_reset_colour", col(), oh(expm[0]));
    rst_n = 1'b0;
    #1;
    check("async_colour", col(), 4'h0);
    check("async_rand_done", bus.rand_done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset five cycles into a fill, then a clean game.
    game(1);
    bus.START = 1'b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midfill_colour", col(), 4'h0);
    check("midfill_rand_done", bus.rand_done, 1'b0);
    check("midfill_i_eq_j", bus.I_eq_J, 1'b1);
    check("midfill_j_max", bus.J_max, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeats = 0;
    game(2);

    for (int g = 3; g < 203; g++) begin
      repeat ($urandom_range(0, 7)) @(posedge clk);
      #1;
      game(g);
    end
`ifdef NO_REPEAT_EN
    check("no_adjacent_repeats", repeats, 0);
`else
    check("some_adjacent_repeat", (repeats > 0), 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
